// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding,
// requester IDs and byte-enable patterns.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RMW     = 2'd2
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_t;

    localparam logic [3:0] BE_FULL = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // A write that touches some but not all byte lanes needs a read-modify-write.
    function automatic logic is_partial(input logic [3:0] be);
        return (be != BE_FULL) && (be != BE_NONE);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's view of the data memory: req/gnt access handshake plus
// the one-cycle-later read return.
interface dmem_arbiter_if;

    // Handshake: the master raises req with we/addr/wdata/be and holds them
    // stable until the cycle gnt=1; gnt is a one-cycle accept (for writes it
    // also means done). For a read, rvalid pulses in the cycle after gnt with
    // rdata; rdata then holds until that port's next read returns.
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: lanes with be[i]=1 take new data, the
// others keep the old word. Shared by the RMW path and sub-word stores.
module dmem_byte_merge (
    input  logic [31:0] wdata,
    input  logic [31:0] old_data,
    input  logic [3:0]  be,
    output logic [31:0] merged
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_data[8*i +: 8];
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port IP_RAM between the CPU memory
// stage and the debug/loader port; partial writes become a two-cycle RMW.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clock,
    input  logic              resetn,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dbg,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    output logic              ram_we,
    input  logic [31:0]       ram_dout,
    output state_t            fsm_state
);

    state_t             state_q, state_d;
    port_t              last_q, last_d;
    port_t              op_port_q, op_port_d;
    logic [ADDR_W-1:0]  op_addr_q, op_addr_d;
    logic [31:0]        op_wdata_q, op_wdata_d;
    logic [3:0]         op_be_q, op_be_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_c;
    logic [31:0]        ram_din_q, ram_din_c;
    logic               ram_we_c;
    logic [31:0]        cpu_rdata_q, dbg_rdata_q;

    logic               grant_c, rvalid_c;
    port_t              resp_port_c;

    port_t              win_port;
    logic               any_req;
    logic               win_we;
    logic [31:0]        win_addr;
    logic [31:0]        win_wdata;
    logic [3:0]         win_be;
    logic [31:0]        merged;

    logic               unused_addr_bits;
    assign unused_addr_bits = ^{cpu.addr[31:ADDR_W+2], cpu.addr[1:0],
                                dbg.addr[31:ADDR_W+2], dbg.addr[1:0]};

    // On contention the port that did not win last time goes first.
    assign any_req  = cpu.req | dbg.req;
    assign win_port = (cpu.req && dbg.req) ? ((last_q == PORT_CPU) ? PORT_DBG : PORT_CPU)
                    : (dbg.req ? PORT_DBG : PORT_CPU);

    assign win_we    = (win_port == PORT_DBG) ? dbg.we    : cpu.we;
    assign win_addr  = (win_port == PORT_DBG) ? dbg.addr  : cpu.addr;
    assign win_wdata = (win_port == PORT_DBG) ? dbg.wdata : cpu.wdata;
    assign win_be    = (win_port == PORT_DBG) ? dbg.be    : cpu.be;

    dmem_byte_merge u_merge (
        .wdata    (op_wdata_q),
        .old_data (ram_dout),
        .be       (op_be_q),
        .merged   (merged)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        op_port_d   = op_port_q;
        op_addr_d   = op_addr_q;
        op_wdata_d  = op_wdata_q;
        op_be_d     = op_be_q;
        ram_addr_c  = ram_addr_q;
        ram_din_c   = ram_din_q;
        ram_we_c    = 1'b0;
        grant_c     = 1'b0;
        rvalid_c    = 1'b0;
        resp_port_c = op_port_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    last_d      = win_port;
                    op_port_d   = win_port;
                    op_addr_d   = win_addr[ADDR_W+1:2];
                    op_wdata_d  = win_wdata;
                    op_be_d     = win_be;
                    ram_addr_c  = win_addr[ADDR_W+1:2];
                    resp_port_c = win_port;
                    if (!win_we) begin
                        grant_c = 1'b1;
                        state_d = RD_WAIT;
                    end else if (win_be == BE_FULL) begin
                        ram_we_c  = 1'b1;
                        ram_din_c = win_wdata;
                        grant_c   = 1'b1;
                    end else if (is_partial(win_be)) begin
                        // Old word is being read now; merged and written next cycle.
                        state_d = RMW;
                    end else begin
                        grant_c = 1'b1;
                    end
                end
            end
            RD_WAIT: begin
                rvalid_c = 1'b1;
                state_d  = IDLE;
            end
            RMW: begin
                ram_addr_c = op_addr_q;
                ram_din_c  = merged;
                ram_we_c   = 1'b1;
                grant_c    = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even with a request pending.
    assign ram_we   = resetn & ram_we_c;
    assign ram_addr = resetn ? ram_addr_c : '0;
    assign ram_din  = resetn ? ram_din_c  : '0;

    assign cpu.gnt    = resetn & grant_c  & (resp_port_c == PORT_CPU);
    assign dbg.gnt    = resetn & grant_c  & (resp_port_c == PORT_DBG);
    assign cpu.rvalid = resetn & rvalid_c & (resp_port_c == PORT_CPU);
    assign dbg.rvalid = resetn & rvalid_c & (resp_port_c == PORT_DBG);
    assign cpu.rdata  = cpu.rvalid ? ram_dout : cpu_rdata_q;
    assign dbg.rdata  = dbg.rvalid ? ram_dout : dbg_rdata_q;

    assign fsm_state = state_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            last_q      <= PORT_DBG;
            op_port_q   <= PORT_CPU;
            op_addr_q   <= '0;
            op_wdata_q  <= '0;
            op_be_q     <= '0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            op_port_q  <= op_port_d;
            op_addr_q  <= op_addr_d;
            op_wdata_q <= op_wdata_d;
            op_be_q    <= op_be_d;
            ram_addr_q <= ram_addr_c;
            ram_din_q  <= ram_din_c;
            if (cpu.rvalid) cpu_rdata_q <= ram_dout;
            if (dbg.rvalid) dbg_rdata_q <= ram_dout;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory IP_RAM between two requesters: the CPU memory stage (cpu_*) and a debug/loader port (dbg_*).
- Round-robin arbitration with a req/gnt handshake and a one-cycle synchronous read return.
- Byte-lane writes are done as a two-cycle read-modify-write, because IP_RAM has only a word write enable.
- Sits between the CPU memory stage and IP_RAM, in place of the direct IP_RAM hookup.

Parameters:
- ADDR_W, 10, IP_RAM word-address width. ram_addr = {x}_addr[ADDR_W+1:2]; addr[1:0] and the upper bits are ignored.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- resetn  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  write data
- cpu_be  in  4  byte enables (bit i = bits 8i+7:8i); ignored for reads
- cpu_gnt  out  1  one-cycle pulse: access accepted (write: completed)
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata valid
- cpu_rdata  out  32  read data
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be, dbg_gnt, dbg_rvalid, dbg_rdata: identical set for the debug port
- ram_addr  out  ADDR_W  to IP_RAM address
- ram_din  out  32  to IP_RAM data in
- ram_we  out  1  to IP_RAM write enable
- ram_dout  in  32  from IP_RAM; valid the cycle after the address is presented

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, last=DBG.
  - All gnt, rvalid and ram_we are 0; both rdata are 0.
  - ram_addr and ram_din are 0.
- States: IDLE, RD_WAIT, RMW.
- IDLE, no req: ram_we=0; outputs hold; stay in IDLE.
- IDLE, arbitration (combinational in cycle N):
  - Only one req high: that port wins.
  - Both high: the port not equal to last wins.
  - The winner's addr/we/wdata/be drive the RAM path combinationally in cycle N.
  - last is updated to the winner at the end of cycle N.
- Read (we=0):
  - Cycle N: ram_we=0, winner gnt=1; next state RD_WAIT.
  - Cycle N+1: winner rdata=ram_dout (registered copy held until that port's next read), winner rvalid=1; no new grant; return to IDLE.
  - Read-to-read throughput is one access every 2 cycles.
- Full write (be=4'b1111): cycle N ram_we=1, ram_din=wdata, gnt=1; stay in IDLE. Back-to-back full writes: one per cycle.
- Null write (be=4'b0000): gnt=1 in cycle N, ram_we=0; stay in IDLE.
- Partial write (any other be):
  - Cycle N: read issued (ram_we=0), no gnt; latch port, addr, wdata, be; next state RMW.
  - Cycle N+1:
    - ram_addr = latched addr.
    - ram_din byte i = be[i] ? wdata byte i : ram_dout byte i.
    - ram_we=1, gnt=1.
    - Return to IDLE.
- Requester rules:
  - The requester holds req/addr/we/wdata/be stable from assertion until its gnt cycle.
  - The requester drops req, or presents a new request, in the cycle after gnt.
  - The arbiter does not check the hold rule; the CPU port is the only one relied on to obey it.
- Each gnt and rvalid is exactly one cycle wide and never asserted for the losing port.
- The losing port waits: a continuously requesting loser is granted at the next IDLE arbitration. There is no starvation; worst-case wait is one access (up to 2 cycles).
- Reset mid-operation:
  - In RD_WAIT: no rvalid is produced.
  - In RMW: the write is abandoned; ram_we must be 0 while resetn=0.

Decomposition:
- Shared package holds: state encoding (IDLE=2'd0, RD_WAIT=2'd1, RMW=2'd2), port IDs (PORT_CPU=1'b0, PORT_DBG=1'b1), BE_FULL=4'b1111.
- One natural sub-module: dmem_byte_merge (combinational 32-bit byte-enable merge of wdata over ram_dout), reused later for sub-word stores.

Test Plan:
- Reset, then cpu read of 0x10 (word 4, preloaded 0xDEADBEEF):
  - cpu_gnt at N, cpu_rvalid and cpu_rdata=0xDEADBEEF at N+1.
  - dbg_* stay 0.
- Both ports request at once after reset (cpu read 0x0, dbg read 0x4):
  - CPU granted first (last=DBG at reset), dbg granted 2 cycles later.
  - Repeat: order alternates.
- dbg full write 0x8 = 0x12345678, then cpu read 0x8:
  - ram_we one cycle; cpu_rdata=0x12345678.
- cpu partial write 0x8, wdata=0xAABBCCDD, be=4'b0101, over 0x12345678:
  - gnt at N+1 only.
  - Word becomes 0x12BB56DD, confirmed by readback.
- cpu write be=4'b0000: gnt in one cycle, ram_we never asserted, memory unchanged.
- Assert resetn low during the RMW cycle of a partial write:
  - ram_we=0, memory unchanged, all outputs at reset values.
  - After release, state is IDLE and the next read is correct.
